// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, fault codes and the
// {pc, instr} entry that travels through the prefetch FIFO.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_e;
  typedef enum logic [1:0] {NONE = 2'd0, MISALIGN = 2'd1, RANGE = 2'd2} fault_cause_e;

  // Default-width view of a FIFO entry; the top builds an XLEN-wide equivalent.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count; flush empties it and beats push.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, FSM, word-addressed instruction RAM with a load port, and a
// prefetch FIFO feeding decode over valid/ready.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 64,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter string           INIT_FILE  = "",
  localparam int             AW         = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            load_we,
  input  logic [AW-1:0]   load_addr,
  input  logic [XLEN-1:0] load_data,
  output logic            fault,
  output logic [1:0]      fault_cause
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] mem [DEPTH];
  fetch_state_e    state;
  logic [XLEN-1:0] pc_q, tag_q, rdata_q;
  logic            inflight;
  logic [CW-1:0]   count;
  logic            empty, pop, redir_ok, can_issue, in_range, issue;
  entry_t          head;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign pop      = !empty && out_ready;
  assign redir_ok = (redirect_pc[1:0] == 2'b00);
  // Credit check counts the word still in flight so the FIFO can never overflow.
  assign can_issue = (state == RUN) && !redirect_valid &&
                     ((int'(count) + int'(inflight) - int'(pop)) < FIFO_DEPTH);
  assign in_range  = (pc_q < XLEN'(4 * DEPTH));
  assign issue     = can_issue && in_range;

  // Read-first: a same-edge load to the issued address returns the old word.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
    if (issue)   rdata_q <= mem[pc_q[AW+1:2]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc_q        <= RESET_PC;
      tag_q       <= '0;
      inflight    <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= NONE;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_q <= pc_q;
        pc_q  <= pc_q + XLEN'(4);
      end
      if (redirect_valid) begin
        inflight <= 1'b0;
        if (!redir_ok) begin
          state       <= FAULT;
          fault       <= 1'b1;
          fault_cause <= MISALIGN;
        end else begin
          pc_q <= redirect_pc;
          if (state == FAULT) begin
            state       <= RUN;
            fault       <= 1'b0;
            fault_cause <= NONE;
          end
        end
      end else begin
        case (state)
          IDLE: if (start) state <= RUN;
          RUN: if (can_issue && !in_range) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_cause <= RANGE;
          end
          default: ;
        endcase
      end
    end
  end

  fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({tag_q, rdata_q}),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
endmodule
